// File: rtl/adder_pipe.sv
// adder_pipe: WIDTH-bit pipelined adder/subtractor built around a Kogge-Stone
// parallel-prefix carry network. A single global stall freezes every stage
// whenever a result is presented but not taken downstream.
module adder_pipe #(
    parameter  int WIDTH = 16,
    localparam int LAT   = $clog2(WIDTH) + 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           a,
    input  logic [WIDTH-1:0]           b,
    input  logic                       cin,
    input  logic [1:0]                 op,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           sum,
    output logic                       cout,
    output logic                       ovf,
    output logic                       zero,
    output logic [$clog2(LAT+1)-1:0]   occ
);

    localparam int LG    = $clog2(WIDTH);
    localparam int OCC_W = $clog2(LAT + 1);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_SBC = 2'b10;

    logic             w_adv;
    logic             w_acc;
    logic             w_xfer;
    logic [WIDTH-1:0] w_b_eff;
    logic             w_c_eff;

    // Stage 1: operands with the effective second operand and carry-in
    logic [WIDTH-1:0] r_a_p1;
    logic [WIDTH-1:0] r_b_p1;
    logic             r_c_p1;
    logic             r_vld_p1;

    // Stage 2 (index 0) and one prefix level per index 1..LG
    logic [WIDTH-1:0] r_g_pfx   [0:LG];
    logic [WIDTH-1:0] r_p_pfx   [0:LG];
    logic [WIDTH-1:0] r_po_pfx  [0:LG];
    logic             r_c_pfx   [0:LG];
    logic             r_am_pfx  [0:LG];
    logic             r_vld_pfx [0:LG];

    logic [WIDTH-1:0] w_g_nxt [1:LG];
    logic [WIDTH-1:0] w_p_nxt [1:LG];

    // Stage LAT-1: sum bits plus what the flag stage still needs
    logic [WIDTH-1:0] r_sum_xor;
    logic             r_cout_xor;
    logic             r_am_xor;
    logic             r_pm_xor;
    logic             r_vld_xor;

    // Stage LAT: registered result and flags
    logic [WIDTH-1:0] r_sum_out;
    logic             r_cout_out;
    logic             r_ovf_out;
    logic             r_zero_out;
    logic             r_vld_out;
    logic [OCC_W-1:0] r_occ;

    // The whole pipe moves together unless the output is blocked
    assign w_adv  = !(r_vld_out && !out_ready);
    assign w_acc  = in_valid && w_adv;
    assign w_xfer = r_vld_out && out_ready;

    // Select the effective second operand and carry for each mode
    always_comb begin
        w_b_eff = b;
        w_c_eff = cin;
        case (op)
            OP_ADD: begin
                w_b_eff = b;
                w_c_eff = cin;
            end
            OP_SUB: begin
                w_b_eff = ~b;
                w_c_eff = 1'b1;
            end
            OP_SBC: begin
                w_b_eff = ~b;
                w_c_eff = cin;
            end
            default: begin
                w_b_eff = '0;
                w_c_eff = 1'b1;
            end
        endcase
    end

    // One Kogge-Stone combine per level, span doubling each level
    always_comb begin
        for (int k = 1; k <= LG; k++) begin
            w_g_nxt[k] = r_g_pfx[k-1];
            w_p_nxt[k] = r_p_pfx[k-1];
            for (int i = 0; i < WIDTH; i++) begin
                int j;
                j = i - (1 << (k - 1));
                if (j >= 0) begin
                    w_g_nxt[k][i] = r_g_pfx[k-1][i] | (r_p_pfx[k-1][i] & r_g_pfx[k-1][j]);
                    w_p_nxt[k][i] = r_p_pfx[k-1][i] & r_p_pfx[k-1][j];
                end
            end
        end
    end

    // Datapath registers for stages 1..LAT-1 (contents only matter when valid)
    always_ff @(posedge clk) begin
        if (w_adv) begin
            r_a_p1 <= a;
            r_b_p1 <= w_b_eff;
            r_c_p1 <= w_c_eff;

            // carry-in is folded into bit 0 generate so G[i] is the carry out of bit i
            r_g_pfx[0]  <= (r_a_p1 & r_b_p1)
                         | {{(WIDTH-1){1'b0}}, (r_a_p1[0] ^ r_b_p1[0]) & r_c_p1};
            r_p_pfx[0]  <= r_a_p1 ^ r_b_p1;
            r_po_pfx[0] <= r_a_p1 ^ r_b_p1;
            r_c_pfx[0]  <= r_c_p1;
            r_am_pfx[0] <= r_a_p1[WIDTH-1];

            for (int k = 1; k <= LG; k++) begin
                r_g_pfx[k]  <= w_g_nxt[k];
                r_p_pfx[k]  <= w_p_nxt[k];
                r_po_pfx[k] <= r_po_pfx[k-1];
                r_c_pfx[k]  <= r_c_pfx[k-1];
                r_am_pfx[k] <= r_am_pfx[k-1];
            end

            r_sum_xor  <= r_po_pfx[LG] ^ {r_g_pfx[LG][WIDTH-2:0], r_c_pfx[LG]};
            r_cout_xor <= r_g_pfx[LG][WIDTH-1];
            r_am_xor   <= r_am_pfx[LG];
            r_pm_xor   <= r_po_pfx[LG][WIDTH-1];
        end
    end

    // Output stage: result and flags, cleared by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum_out  <= '0;
            r_cout_out <= 1'b0;
            r_ovf_out  <= 1'b0;
            r_zero_out <= 1'b0;
        end else if (w_adv) begin
            r_sum_out  <= r_sum_xor;
            r_cout_out <= r_cout_xor;
            // operand MSBs equal (propagate MSB clear) but sum MSB differs from A
            r_ovf_out  <= !r_pm_xor && (r_sum_xor[WIDTH-1] != r_am_xor);
            r_zero_out <= (r_sum_xor == '0);
        end
    end

    // Valid bits travel with the data and freeze on stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p1  <= 1'b0;
            for (int k = 0; k <= LG; k++) begin
                r_vld_pfx[k] <= 1'b0;
            end
            r_vld_xor <= 1'b0;
            r_vld_out <= 1'b0;
        end else if (w_adv) begin
            r_vld_p1     <= in_valid;
            r_vld_pfx[0] <= r_vld_p1;
            for (int k = 1; k <= LG; k++) begin
                r_vld_pfx[k] <= r_vld_pfx[k-1];
            end
            r_vld_xor <= r_vld_pfx[LG];
            r_vld_out <= r_vld_xor;
        end
    end

    // Occupancy: entries accepted and not yet handed downstream
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_occ <= '0;
        end else begin
            case ({w_acc, w_xfer})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign in_ready  = w_adv;
    assign out_valid = r_vld_out;
    assign sum       = r_sum_out;
    assign cout      = r_cout_out;
    assign ovf       = r_ovf_out;
    assign zero      = r_zero_out;
    assign occ       = r_occ;

endmodule

// File: doc/adder_pipe.md
ADDER_PIPE -- requirements
Module: adder_pipe

Interface
REQ-001: Parameter WIDTH, default 16, operand/result width in bits; legal values 4..64, power of two.
REQ-002: Parameter LAT, fixed at $clog2(WIDTH)+4, pipeline latency in cycles; 8 for WIDTH=16; not overridable.
REQ-003: Port clk  input  1  single clock; all state updates on rising edge.
REQ-004: Port rst_n  input  1  asynchronous, active-low reset.
REQ-005: Port in_valid  input  1  operand set presented.
REQ-006: Port in_ready  output  1  block accepts operand set this cycle.
REQ-007: Port a  input  WIDTH  operand A.
REQ-008: Port b  input  WIDTH  operand B.
REQ-009: Port cin  input  1  carry in.
REQ-010: Port op  input  2  mode: 00 ADD, 01 SUB, 10 SBC, 11 INC.
REQ-011: Port out_valid  output  1  result present.
REQ-012: Port out_ready  input  1  downstream accepts result.
REQ-013: Port sum  output  WIDTH  result.
REQ-014: Port cout  output  1  carry out of MSB.
REQ-015: Port ovf  output  1  signed (two's-complement) overflow.
REQ-016: Port zero  output  1  sum equals 0.
REQ-017: Port occ  output  $clog2(LAT+1)  number of valid entries in pipeline.

Function
REQ-018: ADD computes a+b+cin; SUB computes a+~b+1 (cin ignored); SBC computes a+~b+cin; INC computes a+1 (b, cin ignored).
REQ-019: Result is WIDTH+1 bits; sum = low WIDTH bits, cout = bit WIDTH; no saturation, wrap-around modulo 2^WIDTH.
REQ-020: ovf = (A_msb == B'_msb) && (sum_msb != A_msb), where B' is the effective second operand after inversion/substitution.
REQ-021: Structure: stages 1-2 generate/propagate, stages 3..LAT-2 one parallel-prefix (Kogge-Stone) level each, stages LAT-1..LAT sum XOR and flag registers; each stage registered.
REQ-022: Transfer in occurs when in_valid && in_ready; transfer out when out_valid && out_ready.
REQ-023: in_ready = !(out_valid && !out_ready); combinational, no dependence on in_valid.
REQ-024: Stall: when out_valid && !out_ready, every stage, including valid bits, holds its contents.
REQ-025: When not stalled, pipeline advances one stage per cycle; bubbles (in_valid low) propagate as invalid entries and do not block advance.
REQ-026: A set accepted in cycle N with no stalls yields out_valid in cycle N+LAT; each stall cycle adds exactly one cycle.
REQ-027: Results exit strictly in acceptance order; no loss, no duplication.
REQ-028: sum/cout/ovf/zero valid only while out_valid; held stable throughout a stall.
REQ-029: occ increments on accept-only, decrements on output-transfer-only, unchanged on both or neither; never exceeds LAT.
REQ-030: Back-to-back accepts every cycle sustain throughput of one result per cycle with out_ready high.

Reset
REQ-031: rst_n low asynchronously clears all stage valid bits, out_valid=0, occ=0, sum=0, cout=0, ovf=0, zero=0.
REQ-032: in_ready=1 during and after reset; reset mid-operation discards all in-flight entries, none emerge.
REQ-033: First accept permitted on first rising clk edge after rst_n deasserts.

Verification
REQ-034: WIDTH=16, ADD a=0xFFFF b=0x0001 cin=0 -> after 8 cycles sum=0x0000 cout=1 ovf=0 zero=1.
REQ-035: SUB a=0x8000 b=0x0001 -> sum=0x7FFF cout=1 ovf=1 zero=0; INC a=0x7FFF -> sum=0x8000 ovf=1 cout=0.
REQ-036: 20 back-to-back ADD sets, out_ready=1 -> 20 results on consecutive cycles starting 8 cycles after first accept, order preserved, occ peaks at 8.
REQ-037: Fill pipeline, hold out_ready=0 for 5 cycles -> in_ready=0, outputs and occ=8 stable, then resume with no loss or duplication.
REQ-038: Accept 3 sets, assert rst_n=0 mid-flight for 1 cycle -> out_valid never asserts for them, occ=0, in_ready=1.
REQ-039: WIDTH=32 and WIDTH=8 builds, random op/operands vs reference model -> latency 9 and 7 respectively, all results bit-exact.
